// File: rtl/rv32_mc_pkg.sv
// Purpose: shared types, codes and helpers for the E-stage multicycle sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rv32_mc_pkg;

  localparam int ALU_CONTROL_WIDTH = 5;

  // Decoded ALU control codes seen by the E stage
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_AND    = 5'd2;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OR     = 5'd3;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_XOR    = 5'd4;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLL    = 5'd5;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MUL    = 5'd8;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MULH   = 5'd9;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MULHSU = 5'd10;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MULHU  = 5'd11;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIV    = 5'd12;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIVU   = 5'd13;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REM    = 5'd14;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REMU   = 5'd15;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_FDIV   = 5'd16;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_FSQRT  = 5'd17;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_FMADD  = 5'd18;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_FMSUB  = 5'd19;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_FNMSUB = 5'd20;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_FNMADD = 5'd21;

  localparam logic [1:0] UNIT_IDIV = 2'd0;
  localparam logic [1:0] UNIT_FDIV = 2'd1;
  localparam logic [1:0] UNIT_FMA  = 2'd2;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mc_state_t;

  typedef struct packed {
    logic       mc;
    logic [1:0] unit;
  } mc_class_t;

  // Map an ALU control code to {is multicycle, owning unit}
  function automatic mc_class_t is_multicycle(input logic [ALU_CONTROL_WIDTH-1:0] alu_control);
    mc_class_t c;
    c.mc   = 1'b0;
    c.unit = UNIT_IDIV;
    case (alu_control)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        c.mc   = 1'b1;
        c.unit = UNIT_IDIV;
      end
      ALU_FDIV, ALU_FSQRT: begin
        c.mc   = 1'b1;
        c.unit = UNIT_FDIV;
      end
      ALU_FMADD, ALU_FMSUB, ALU_FNMSUB, ALU_FNMADD: begin
        c.mc   = 1'b1;
        c.unit = UNIT_FMA;
      end
      default: begin
        c.mc   = 1'b0;
        c.unit = UNIT_IDIV;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv32_e_mc_timeout_counter.sv
// Purpose: per-operation watchdog counter with terminal-count flag.
// Latency: terminal_o is combinational from the registered count.
// Backpressure: none; counts while enabled and saturates at terminal count.
module rv32_e_mc_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q;

  assign terminal_o = (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Clear on issue, count up while waiting, hold once the terminal count is hit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !terminal_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/rv32_e_multicycle_ctrl.sv
// Purpose: E-stage sequencer that stalls, starts and waits on IDIV/FDIV/FMA units, one result beat per op.
// Latency: accept T, start T+1, result beat >= T+3; divide special cases return at T+1.
// Backpressure: stall_o holds E and upstream from accept through WAIT; released in the result beat.
module rv32_e_multicycle_ctrl
  import rv32_mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NUM_UNITS      = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic                         flush_i,
  input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_i,
  input  logic [31:0]                  rs1_i,
  input  logic [31:0]                  rs2_i,
  output logic                         stall_o,
  output logic [NUM_UNITS-1:0]         unit_start_o,
  output logic [NUM_UNITS-1:0]         unit_kill_o,
  output logic [ALU_CONTROL_WIDTH-1:0] unit_op_o,
  input  logic [NUM_UNITS-1:0]         unit_done_i,
  input  logic [NUM_UNITS*32-1:0]      unit_result_i,
  input  logic [NUM_UNITS*5-1:0]       unit_fflags_i,
  output logic                         result_valid_o,
  output logic [31:0]                  result_o,
  output logic [4:0]                   fflags_o,
  output logic                         timeout_o
);

  mc_state_t                    state_q, state_d;
  logic [ALU_CONTROL_WIDTH-1:0] op_q;
  logic [1:0]                   sel_q;
  logic [31:0]                  result_q;
  logic [4:0]                   fflags_q;
  logic                         timeout_q;

  mc_class_t cls;
  logic      accept, is_idiv, is_signed, is_rem, div_zero, div_ovf, fast_path;
  logic [31:0] fast_result;
  logic [NUM_UNITS-1:0] sel_oh;
  logic      sel_done, tc;
  logic      ld_done, ld_timeout;
  logic [31:0] sel_result;
  logic [4:0]  sel_fflags;

  assign cls       = is_multicycle(alu_control_i);
  assign accept    = (state_q == ST_IDLE) && valid_i && cls.mc && !flush_i;
  assign is_idiv   = (cls.unit == UNIT_IDIV);
  assign is_signed = (alu_control_i == ALU_DIV) || (alu_control_i == ALU_REM);
  assign is_rem    = (alu_control_i == ALU_REM) || (alu_control_i == ALU_REMU);
  assign div_zero  = is_idiv && (rs2_i == 32'd0);
  assign div_ovf   = is_signed && (rs1_i == INT_MIN) && (rs2_i == 32'hFFFF_FFFF);
  assign fast_path = div_zero || div_ovf;
  // Division by zero wins over the signed overflow pattern (rs2 cannot be both)
  assign fast_result = div_zero ? (is_rem ? rs1_i : DIV_ZERO_Q)
                                : (is_rem ? 32'd0 : INT_MIN);

  assign sel_oh   = NUM_UNITS'(1) << sel_q;
  assign sel_done = |(unit_done_i & sel_oh);

  // Pick the selected unit's result and flags
  always_comb begin
    sel_result = unit_result_i[31:0];
    sel_fflags = unit_fflags_i[4:0];
    case (sel_q)
      UNIT_FDIV: begin
        sel_result = unit_result_i[63:32];
        sel_fflags = unit_fflags_i[9:5];
      end
      UNIT_FMA: begin
        sel_result = unit_result_i[95:64];
        sel_fflags = unit_fflags_i[14:10];
      end
      default: begin
        sel_result = unit_result_i[31:0];
        sel_fflags = unit_fflags_i[4:0];
      end
    endcase
  end

  rv32_e_mc_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == ST_ISSUE),
    .enable_i  (state_q == ST_WAIT),
    .terminal_o(tc)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and control pulses; flush outranks done, timeout and accept
  always_comb begin
    state_d        = state_q;
    stall_o        = 1'b0;
    unit_start_o   = '0;
    unit_kill_o    = '0;
    result_valid_o = 1'b0;
    ld_done        = 1'b0;
    ld_timeout     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = fast_path ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        stall_o = 1'b1;
        if (flush_i) begin
          unit_kill_o = sel_oh;
          state_d     = ST_IDLE;
        end else begin
          unit_start_o = sel_oh;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (flush_i) begin
          unit_kill_o = sel_oh;
          state_d     = ST_IDLE;
        end else if (sel_done) begin
          ld_done = 1'b1;
          state_d = ST_RESP;
        end else if (tc) begin
          unit_kill_o = sel_oh;
          ld_timeout  = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        result_valid_o = !flush_i;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch op/unit on accept and the response payload when its source resolves
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= '0;
      sel_q     <= UNIT_IDIV;
      result_q  <= '0;
      fflags_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= alu_control_i;
        sel_q <= cls.unit;
        if (fast_path) begin
          result_q  <= fast_result;
          fflags_q  <= '0;
          timeout_q <= 1'b0;
        end
      end
      if (ld_done) begin
        result_q  <= sel_result;
        fflags_q  <= sel_fflags;
        timeout_q <= 1'b0;
      end
      if (ld_timeout) begin
        result_q  <= '0;
        fflags_q  <= '0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign unit_op_o = op_q;
  assign result_o  = result_q;
  assign fflags_o  = fflags_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rv32_e_multicycle_ctrl.sv
// Purpose: directed self-checking bench for the E-stage multicycle sequencer.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: unit responses are scripted per test.
module tb_rv32_e_multicycle_ctrl;
  import rv32_mc_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         valid;
  logic                         flush;
  logic [ALU_CONTROL_WIDTH-1:0] alu_control;
  logic [31:0]                  rs1, rs2;
  logic                         stall;
  logic [2:0]                   unit_start, unit_kill, unit_done;
  logic [ALU_CONTROL_WIDTH-1:0] unit_op;
  logic [95:0]                  unit_result;
  logic [14:0]                  unit_fflags;
  logic                         result_valid;
  logic [31:0]                  result;
  logic [4:0]                   fflags;
  logic                         timeout;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int s0;

  rv32_e_multicycle_ctrl #(.TIMEOUT_CYCLES(8), .NUM_UNITS(3)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
    .alu_control_i(alu_control), .rs1_i(rs1), .rs2_i(rs2),
    .stall_o(stall), .unit_start_o(unit_start), .unit_kill_o(unit_kill),
    .unit_op_o(unit_op), .unit_done_i(unit_done), .unit_result_i(unit_result),
    .unit_fflags_i(unit_fflags), .result_valid_o(result_valid),
    .result_o(result), .fflags_o(fflags), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (|unit_start) starts <= starts + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  32'(stall), 0);
    chk({tag, "_start"},  32'(unit_start), 0);
    chk({tag, "_kill"},   32'(unit_kill), 0);
    chk({tag, "_op"},     32'(unit_op), 0);
    chk({tag, "_rv"},     32'(result_valid), 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_fflags"}, 32'(fflags), 0);
    chk({tag, "_timeout"},32'(timeout), 0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; alu_control = ALU_ADD;
    rs1 = '0; rs2 = '0; unit_done = '0; unit_result = '0; unit_fflags = '0;
    next();
    chk_all_zero("reset");
    rst = 1'b0;
    next();

    // DIVU 100/7, unit answers 5 cycles after start with 14
    valid = 1'b1; alu_control = ALU_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    unit_result = {32'hCCCC_0002, 32'hCCCC_0001, 32'd14};
    unit_fflags = {5'h1F, 5'h1F, 5'h00};
    mid(); chk("divu_T_stall", 32'(stall), 1); chk("divu_T_start", 32'(unit_start), 0);
    next();
    valid = 1'b0;
    mid(); chk("divu_T1_start", 32'(unit_start), 32'h1); chk("divu_T1_stall", 32'(stall), 1);
    next();
    for (int i = 0; i < 4; i++) begin
      unit_done = (i == 1) ? 3'b010 : 3'b000;
      mid();
      chk("divu_wait_stall", 32'(stall), 1);
      chk("divu_wait_start", 32'(unit_start), 0);
      chk("divu_wait_rv", 32'(result_valid), 0);
      chk("divu_wait_op", 32'(unit_op), 32'(ALU_DIVU));
      next();
    end
    unit_done = 3'b001;
    mid(); chk("divu_T6_stall", 32'(stall), 1);
    next();
    unit_done = 3'b000;
    mid();
    chk("divu_T7_rv", 32'(result_valid), 1);
    chk("divu_T7_result", result, 32'd14);
    chk("divu_T7_fflags", 32'(fflags), 0);
    chk("divu_T7_timeout", 32'(timeout), 0);
    chk("divu_T7_stall", 32'(stall), 0);
    next();
    mid(); chk("divu_T8_rv", 32'(result_valid), 0); chk("divu_T8_hold", result, 32'd14);
    next();

    // DIV by zero: fast path, no start
    s0 = starts;
    valid = 1'b1; alu_control = ALU_DIV; rs1 = 32'd5; rs2 = 32'd0;
    mid(); chk("div0_T_stall", 32'(stall), 1);
    next();
    valid = 1'b0;
    mid();
    chk("div0_T1_rv", 32'(result_valid), 1);
    chk("div0_T1_result", result, 32'hFFFF_FFFF);
    chk("div0_T1_start", 32'(unit_start), 0);
    chk("div0_T1_stall", 32'(stall), 0);
    next();

    // REM signed overflow
    valid = 1'b1; alu_control = ALU_REM; rs1 = 32'h8000_0000; rs2 = 32'hFFFF_FFFF;
    mid(); next();
    valid = 1'b0;
    mid(); chk("removf_rv", 32'(result_valid), 1); chk("removf_result", result, 32'd0);
    next();

    // DIV signed overflow
    valid = 1'b1; alu_control = ALU_DIV; rs1 = 32'h8000_0000; rs2 = 32'hFFFF_FFFF;
    mid(); next();
    valid = 1'b0;
    mid(); chk("divovf_rv", 32'(result_valid), 1); chk("divovf_result", result, 32'h8000_0000);
    next();

    // REMU by zero returns the dividend
    valid = 1'b1; alu_control = ALU_REMU; rs1 = 32'd12345; rs2 = 32'd0;
    mid(); next();
    valid = 1'b0;
    mid(); chk("remu0_rv", 32'(result_valid), 1); chk("remu0_result", result, 32'd12345);
    next();
    chk("fast_no_starts", 32'(starts - s0), 0);

    // FDIV flushed in the second WAIT cycle; a late done must not produce a beat
    valid = 1'b1; alu_control = ALU_FDIV; rs1 = 32'd1; rs2 = 32'd3;
    mid(); next();
    valid = 1'b0;
    mid(); chk("fdiv_start", 32'(unit_start), 32'h2);
    next();
    mid(); chk("fdiv_w1_kill", 32'(unit_kill), 0);
    next();
    flush = 1'b1;
    mid();
    chk("fdiv_flush_kill", 32'(unit_kill), 32'h2);
    chk("fdiv_flush_start", 32'(unit_start), 0);
    chk("fdiv_flush_rv", 32'(result_valid), 0);
    next();
    flush = 1'b0; unit_done = 3'b010;
    mid(); chk("fdiv_idle_stall", 32'(stall), 0); chk("fdiv_idle_rv", 32'(result_valid), 0);
    next();
    unit_done = 3'b000;
    mid(); chk("fdiv_after_rv", 32'(result_valid), 0);
    next();

    // FMADD with no response: watchdog kills on the 8th WAIT cycle
    valid = 1'b1; alu_control = ALU_FMADD;
    mid(); next();
    valid = 1'b0;
    mid(); chk("fma_start", 32'(unit_start), 32'h4);
    next();
    for (int i = 0; i < 7; i++) begin
      mid(); chk("fma_wait_kill", 32'(unit_kill), 0); chk("fma_wait_stall", 32'(stall), 1);
      next();
    end
    mid(); chk("fma_to_kill", 32'(unit_kill), 32'h4); chk("fma_to_rv", 32'(result_valid), 0);
    next();
    mid();
    chk("fma_to_beat_rv", 32'(result_valid), 1);
    chk("fma_to_beat_timeout", 32'(timeout), 1);
    chk("fma_to_beat_result", result, 0);
    next();

    // FMSUB completes with flags from the FMA unit
    valid = 1'b1; alu_control = ALU_FMSUB;
    unit_result = {32'h3F80_0000, 32'hDEAD_0001, 32'hDEAD_0000};
    unit_fflags = {5'h01, 5'h10, 5'h08};
    mid(); next();
    valid = 1'b0;
    mid(); next();
    unit_done = 3'b100;
    mid(); next();
    unit_done = 3'b000;
    mid();
    chk("fms_rv", 32'(result_valid), 1);
    chk("fms_result", result, 32'h3F80_0000);
    chk("fms_fflags", 32'(fflags), 32'h01);
    chk("fms_timeout", 32'(timeout), 0);
    next();

    // Single-cycle ADD passes through
    valid = 1'b1; alu_control = ALU_ADD;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("add_stall", 32'(stall), 0);
      chk("add_start", 32'(unit_start), 0);
      chk("add_kill", 32'(unit_kill), 0);
      chk("add_rv", 32'(result_valid), 0);
      next();
    end
    valid = 1'b0;

    // Back-to-back DIVs; the second is seen in RESP but accepted in the following IDLE
    s0 = starts;
    valid = 1'b1; alu_control = ALU_DIV; rs1 = 32'd20; rs2 = 32'd3;
    unit_result = {32'd0, 32'd0, 32'd6}; unit_fflags = '0;
    mid(); next();
    mid(); chk("b2b_a_start", 32'(unit_start), 32'h1);
    next();
    unit_done = 3'b001;
    mid(); next();
    unit_done = 3'b000; rs1 = 32'd21; unit_result = {32'd0, 32'd0, 32'd7};
    mid();
    chk("b2b_a_rv", 32'(result_valid), 1);
    chk("b2b_a_result", result, 32'd6);
    chk("b2b_resp_stall", 32'(stall), 0);
    next();
    mid(); chk("b2b_b_accept_stall", 32'(stall), 1);
    next();
    valid = 1'b0;
    mid(); chk("b2b_b_start", 32'(unit_start), 32'h1);
    next();
    unit_done = 3'b001;
    mid(); next();
    unit_done = 3'b000;
    mid(); chk("b2b_b_rv", 32'(result_valid), 1); chk("b2b_b_result", result, 32'd7);
    next();
    chk("b2b_two_starts", 32'(starts - s0), 2);

    // Done and flush together in WAIT: flush wins
    valid = 1'b1; alu_control = ALU_FSQRT;
    unit_result = {32'd0, 32'd5, 32'd0};
    mid(); next();
    valid = 1'b0;
    mid(); next();
    unit_done = 3'b010; flush = 1'b1;
    mid(); chk("df_kill", 32'(unit_kill), 32'h2); chk("df_rv", 32'(result_valid), 0);
    next();
    unit_done = 3'b000; flush = 1'b0;
    mid();
    chk("df_idle_stall", 32'(stall), 0);
    chk("df_idle_rv", 32'(result_valid), 0);
    chk("df_result_held", result, 32'd7);
    next();

    // Asynchronous reset in the middle of WAIT
    valid = 1'b1; alu_control = ALU_DIVU; rs1 = 32'd9; rs2 = 32'd2;
    mid(); next();
    valid = 1'b0;
    mid(); next();
    mid(); chk("ar_pre_stall", 32'(stall), 1);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    next();
    rst = 1'b0;
    next();
    mid(); chk("ar_post_stall", 32'(stall), 0); chk("ar_post_rv", 32'(result_valid), 0);
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
